// File: rtl/scale_mux_pkg.sv
// Shared types for the scale_mux datapath and its round-robin arbiter.
package scale_mux_pkg;

  localparam int SCALE_MUX_W = 8;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

endpackage

// File: rtl/scale_mux_arb_if.sv
// Two-source valid/ready bundle plus the registered output slot.
interface scale_mux_arb_if #(
  parameter int WIDTH = 8
);

  logic             in_a_valid;
  logic [WIDTH-1:0] in_a;
  logic             in_a_ready;
  logic             in_b_valid;
  logic [WIDTH-1:0] in_b;
  logic             in_b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport master (
    output in_a_valid, in_a,
    output in_b_valid, in_b,
    output out_ready,
    input  in_a_ready, in_b_ready,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  in_a_valid, in_a,
    input  in_b_valid, in_b,
    input  out_ready,
    output in_a_ready, in_b_ready,
    output out_valid, out_data, out_src
  );

endinterface

// File: rtl/scale_mux.sv
// Two-input word select used as the shared datapath.
module scale_mux
  import scale_mux_pkg::*;
#(
  parameter int W = SCALE_MUX_W
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         sel_b,
  output logic [W-1:0] out
);

  assign out = sel_b ? in_b : in_a;

endmodule

// File: rtl/scale_mux_arb.sv
// Round-robin arbiter feeding one scale_mux into a single output slot.
// Define SCALE_MUX_ARB_STATS_EN for saturating accept counters.
module scale_mux_arb
  import scale_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef SCALE_MUX_ARB_STATS_EN
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
`endif
  scale_mux_arb_if.slave  bus
);

  if (WIDTH != SCALE_MUX_W) begin : g_bad_width
    $error("scale_mux_arb: WIDTH must be 8");
  end

  slot_e            state_q;
  slot_e            state_d;
  src_e             last_q;
  src_e             src_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mux_out;
  logic             slot_free;
  logic             gnt_a;
  logic             gnt_b;
  logic             acc_a;
  logic             acc_b;
  logic             accept;

  assign slot_free = (state_q == SLOT_EMPTY) || bus.out_ready;

  assign gnt_a = bus.in_a_valid
              && (!bus.in_b_valid || last_q == SRC_B);
  assign gnt_b = bus.in_b_valid
              && (!bus.in_a_valid || last_q == SRC_A);

  // Readies are forced low while reset is asserted.
  assign acc_a  = !rst && slot_free && gnt_a;
  assign acc_b  = !rst && slot_free && gnt_b;
  assign accept = acc_a || acc_b;

  assign bus.in_a_ready = acc_a;
  assign bus.in_b_ready = acc_b;
  assign bus.out_valid  = (state_q == SLOT_FULL);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;

  scale_mux #(
    .W (WIDTH)
  ) u_mux (
    .in_a  (bus.in_a),
    .in_b  (bus.in_b),
    .sel_b (gnt_b),
    .out   (mux_out)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:
        if (bus.out_ready && !accept)
          state_d = SLOT_EMPTY;
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      src_q   <= SRC_A;
      last_q  <= SRC_B;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= mux_out;
        src_q  <= gnt_b ? SRC_B : SRC_A;
        last_q <= gnt_b ? SRC_B : SRC_A;
      end
    end
  end

`ifdef SCALE_MUX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (acc_a && cnt_a != '1)
        cnt_a <= cnt_a + CNT_W'(1);
      if (acc_b && cnt_b != '1)
        cnt_b <= cnt_b + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_scale_mux_arb.sv
// Directed bench for scale_mux_arb: reset, lone source,
// contention, backpressure, mid-transfer reset, stats.
module tb_scale_mux_arb;

`ifdef SCALE_MUX_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

`ifdef SCALE_MUX_ARB_STATS_EN
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
`endif

  scale_mux_arb_if #(.WIDTH(8)) bus ();

  scale_mux_arb #(
    .WIDTH (8),
    .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SCALE_MUX_ARB_STATS_EN
    .cnt_a (cnt_a),
    .cnt_b (cnt_b),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [7:0] d,
                         input logic s);
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'(v));
    chk({tag, "_data"}, 16'(bus.out_data), 16'(d));
    chk({tag, "_src"}, 16'(bus.out_src), 16'(s));
  endtask

  initial begin
    bus.in_a_valid = 1'b1;
    bus.in_a       = 8'hff;
    bus.in_b_valid = 1'b0;
    bus.in_b       = 8'h00;
    bus.out_ready  = 1'b1;

    // reset held two cycles with A valid
    tick();
    tick();
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    chk("rst_a_ready", 16'(bus.in_a_ready), 16'd0);
    chk("rst_b_ready", 16'(bus.in_b_ready), 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 16'(bus.in_a_ready), 16'd1);
    tick();
    chk_out("first_acc", 1'b1, 8'hff, 1'b0);

    // lone A stream
    bus.in_a = 8'h00;
    tick();
    chk_out("lone_a0", 1'b1, 8'h00, 1'b0);
    bus.in_a = 8'hff;
    tick();
    chk_out("lone_a1", 1'b1, 8'hff, 1'b0);
    bus.in_a = 8'h0f;
    tick();
    chk_out("lone_a2", 1'b1, 8'h0f, 1'b0);

    // lone B word moves the pointer to B
    bus.in_a_valid = 1'b0;
    bus.in_b_valid = 1'b1;
    bus.in_b       = 8'h3c;
    tick();
    chk_out("lone_b", 1'b1, 8'h3c, 1'b1);

    // contention: A first, then strict alternation
    bus.in_a_valid = 1'b1;
    bus.in_a       = 8'haa;
    bus.in_b       = 8'h55;
    #1;
    chk("cont_a_rdy0", 16'(bus.in_a_ready), 16'd1);
    chk("cont_b_rdy0", 16'(bus.in_b_ready), 16'd0);
    tick();
    chk_out("cont0", 1'b1, 8'haa, 1'b0);
    chk("cont_a_rdy1", 16'(bus.in_a_ready), 16'd0);
    chk("cont_b_rdy1", 16'(bus.in_b_ready), 16'd1);
    tick();
    chk_out("cont1", 1'b1, 8'h55, 1'b1);
    tick();
    chk_out("cont2", 1'b1, 8'haa, 1'b0);
    tick();
    chk_out("cont3", 1'b1, 8'h55, 1'b1);

    // fill slot with ff from A
    bus.in_b_valid = 1'b0;
    bus.in_a       = 8'hff;
    tick();
    chk_out("bp_fill", 1'b1, 8'hff, 1'b0);

    // backpressure with B waiting
    bus.out_ready  = 1'b0;
    bus.in_a_valid = 1'b0;
    bus.in_b_valid = 1'b1;
    bus.in_b       = 8'h55;
    #1;
    chk("bp_b_rdy", 16'(bus.in_b_ready), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 8'hff, 1'b0);
      chk("bp_hold_b_rdy", 16'(bus.in_b_ready), 16'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 16'(bus.in_b_ready), 16'd1);
    tick();
    chk_out("bp_release", 1'b1, 8'h55, 1'b1);

    // mid-transfer reset while holding B word
    bus.out_ready  = 1'b0;
    bus.in_b_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    bus.out_ready  = 1'b1;
    bus.in_a_valid = 1'b1;
    bus.in_a       = 8'haa;
    bus.in_b_valid = 1'b1;
    bus.in_b       = 8'h55;
    #1;
    chk("mid_a_rdy", 16'(bus.in_a_ready), 16'd1);
    chk("mid_b_rdy", 16'(bus.in_b_ready), 16'd0);
    tick();
    chk_out("mid_first", 1'b1, 8'haa, 1'b0);
    tick();
    chk_out("mid_second", 1'b1, 8'h55, 1'b1);

`ifdef SCALE_MUX_ARB_STATS_EN
    // stats: 5 A accepts, 2 B accepts, 2-bit counters
    bus.in_a_valid = 1'b0;
    bus.in_b_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("st_rst_a", 16'(cnt_a), 16'd0);
    chk("st_rst_b", 16'(cnt_b), 16'd0);
    rst = 1'b0;
    bus.in_a_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.in_a_valid = 1'b0;
    bus.in_b_valid = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    bus.in_b_valid = 1'b0;
    tick();
    chk("st_cnt_a", 16'(cnt_a), 16'd3);
    chk("st_cnt_b", 16'(cnt_b), 16'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/scale_mux_arb.md
# scale_mux_arb

Two-requester round-robin arbiter that shares one `scale_mux` datapath between an A source and a B source. Each source offers 8-bit words with a valid/ready handshake. The arbiter drives the mux `sel_b` from its grant decision and registers the selected word into a single output slot. It sits directly in front of `scale_mux` and is the only block that drives its select line.

## Interface
- `WIDTH`, 8, data width; fixed at 8 to match `scale_mux`, and elaboration fails on any other value.
- `CNT_W`, 16, width of the statistics counters; used only with `SCALE_MUX_ARB_STATS_EN`.

Clock and reset are `clk` and `rst`: one clock, and reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_a_valid`  in  1  requester A has a word.
- `in_a`  in  WIDTH  requester A data.
- `in_a_ready`  out  1  A word accepted this cycle when high together with `in_a_valid`.
- `in_b_valid`  in  1  requester B has a word.
- `in_b`  in  WIDTH  requester B data.
- `in_b_ready`  out  1  B word accepted this cycle when high together with `in_b_valid`.
- `out_valid`  out  1  output slot holds a word.
- `out_data`  out  WIDTH  registered selected word.
- `out_src`  out  1  source of `out_data`: 0 = A, 1 = B.
- `out_ready`  in  1  downstream takes `out_data` when high together with `out_valid`.
- `cnt_a`, `cnt_b`  out  CNT_W  accepted-word counters; present only with `SCALE_MUX_ARB_STATS_EN`.

## Operation
- **Slot free:** `slot_free = !out_valid || out_ready`.
- **Grant (combinational):**
  - `gnt_a = in_a_valid && (!in_b_valid || last == B)`.
  - `gnt_b = in_b_valid && (!in_a_valid || last == A)`.
  - At most one grant is high in any cycle.
- **Ready outputs:** `in_a_ready = slot_free && gnt_a`; `in_b_ready = slot_free && gnt_b`.
  - A ready never depends on `out_data`.
  - Sources must not wait for ready before asserting valid.
- **Mux select:** `sel_b = gnt_b`. The mux output is captured when `slot_free` is high and either grant is high.
- **Slot state machine:**
  - EMPTY: `out_valid = 0`.
  - FULL: `out_valid = 1`.
  - EMPTY goes to FULL on an accept.
  - FULL goes to EMPTY on `out_ready` with no accept.
  - FULL stays FULL on `out_ready` with an accept; the new word replaces the old one in the same edge.
  - FULL stays FULL without `out_ready`; `out_data` and `out_src` are held stable.
- **Priority pointer `last`:**
  - Updated to the granted source on every accept; unchanged otherwise.
  - When both sources stay valid, grants alternate strictly.
  - A lone valid source is granted every free cycle (no idle slots).
- **Reset** (including mid-transfer):
  - Clears `out_valid` to 0.
  - Sets `out_data` and `out_src` to 0.
  - Sets `last` to B, so A wins the first contended grant.
  - Discards any held word.
  - Holds `in_a_ready` and `in_b_ready` low while `rst` is high.

## Timing
- Latency from accept edge to `out_valid`: 1 cycle.
- Throughput: 1 word per cycle while `out_ready` is high.
- Backpressure: while `out_valid && !out_ready`, both readies are low and no state changes.
- Both sources valid and slot free: exactly one accept per cycle, and the loser's ready is low.
- Reset values:
  - `out_valid = 0`, `out_data = 8'h00`, `out_src = 0`.
  - `in_a_ready = in_b_ready = 0` during `rst`; they are combinational from the cycle after.
  - `cnt_a = cnt_b = 0`.

## Configuration
- **`SCALE_MUX_ARB_STATS_EN` defined:**
  - `cnt_a` and `cnt_b` exist.
  - Each increments by 1 on its source's accept.
  - Each saturates at all-ones and holds there.
  - Both are cleared by `rst`.
- **Not defined:** ports and counters are absent, and arbitration behaviour is identical.

## Structure
- **Package `scale_mux_pkg`:**
  - `localparam int SCALE_MUX_W = 8`.
  - `typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e`, used for `last` and `out_src`.
  - `typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e`.
- **Sub-module:** one instance of the existing `scale_mux` (`in_a`, `in_b`, `sel_b`, `out`) provides the data selection. The arbiter adds the grant logic, the slot register and the counters.

## Test plan
- **Reset:**
  - Stimulus: `rst` high for 2 cycles with A valid at `8'hff`.
  - Required: `out_valid = 0`, `in_a_ready = 0`, `out_data = 8'h00`; first accept occurs 1 cycle after `rst` drops.
- **Lone A:**
  - Stimulus: A valid with `8'h00`, `8'hff`, `8'h0f`; `out_ready = 1`.
  - Required: outputs `00`, `ff`, `0f` on consecutive cycles with `out_src = 0`.
- **Contention:**
  - Stimulus: A=`8'haa` and B=`8'h55` both valid for 4 cycles; `out_ready = 1`.
  - Required: `out_src` sequence 0,1,0,1 with data `aa`,`55`,`aa`,`55`.
- **Backpressure:**
  - Stimulus: slot FULL with `8'hff`, `out_ready = 0` for 3 cycles while B is valid.
  - Required: `out_data` holds `ff` and `in_b_ready = 0`; B is accepted in the cycle `out_ready` rises, with no bubble.
- **Mid-transfer reset:**
  - Stimulus: pulse `rst` while FULL with B data `8'h55`.
  - Required: `out_valid = 0` next cycle; then with both sources valid, A is granted first.
- **Stats (macro on, `CNT_W = 2`):**
  - Stimulus: 5 A accepts and 2 B accepts.
  - Required: `cnt_a = 3` (saturated) and `cnt_b = 2`.
